// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down modulo counter with prescaler, load, clear,
// wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module sync_updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MOD_VAL  = 16,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MOD_VAL - 64'd1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] load_q;
  logic             tc_next;
  logic             ovf_next;
  logic             step;
  logic             at_limit;

  // Out-of-range load values clamp to the top of the count range
  assign load_q = (64'(load_val) >= MOD_VAL) ? MAX_Q : load_val;

  always_comb begin
    q_next   = q;
    pre_next = pre;
    step     = 1'b0;
    at_limit = 1'b0;

    if (clear) begin
      q_next   = '0;
      pre_next = '0;
    end else if (load) begin
      q_next   = load_q;
      pre_next = '0;
    end else if (en) begin
      if (pre == PRE_LAST) begin
        pre_next = '0;
        step     = 1'b1;
      end else begin
        pre_next = pre + PW'(1);
      end
    end

    // Direction and mode only matter on the step edge itself
    if (step) begin
      at_limit = up ? (q == MAX_Q) : (q == '0);
      if (at_limit) begin
        q_next = sat_mode ? q : (up ? '0 : MAX_Q);
      end else begin
        q_next = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      end
    end

    tc_next  = at_limit;
    ovf_next = at_limit | (ovf & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= '0;
      pre <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      pre <= pre_next;
      tc  <= tc_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: two counter instances (PRESCALE 1 and 3, MOD_VAL 10)
// checked against vector tables, hand sequences and an arithmetic reference model.
module tb_sync_updown_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up, sat_mode, clear, load, ovf_clr;
  logic [W-1:0] load_val;
  logic [W-1:0] qa, qb;
  logic         tca, tcb, ovfa, ovfb;

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 3
  int mq[2];
  int mpre[2];
  bit mtc[2];
  bit movf[2];
  int mmod[2]  = '{10, 10};
  int mpres[2] = '{1, 3};

  typedef struct {
    logic         en, up, sat, clr, ld;
    logic [W-1:0] lv;
    logic         oc;
    logic [W-1:0] q;
    logic         tc, ovf;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(W), .MOD_VAL(10), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(rst), .en(en), .up(up), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .q(qa), .tc(tca), .ovf(ovfa)
  );

  sync_updown_counter #(.WIDTH(W), .MOD_VAL(10), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(rst), .en(en), .up(up), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .q(qb), .tc(tcb), .ovf(ovfb)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mpre[i] = 0; mtc[i] = 0; movf[i] = 0;
    end
  endtask

  // Next state from the counting rules using plain integer arithmetic
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int t;
      bit boundary;
      boundary = 0;
      if (clear) begin
        mq[i] = 0; mpre[i] = 0;
      end else if (load) begin
        mq[i] = (int'(load_val) >= mmod[i]) ? mmod[i] - 1 : int'(load_val);
        mpre[i] = 0;
      end else if (en) begin
        mpre[i] = (mpre[i] + 1) % mpres[i];
        if (mpre[i] == 0) begin
          t = mq[i] + (up ? 1 : -1);
          if (t < 0 || t >= mmod[i]) begin
            boundary = 1;
            if (!sat_mode) mq[i] = (t + mmod[i]) % mmod[i];
          end else begin
            mq[i] = t;
          end
        end
      end
      mtc[i]  = boundary;
      movf[i] = boundary || (movf[i] && !ovf_clr);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".qa"},   int'(qa),   mq[0]);
    check({tag, ".tca"},  int'(tca),  int'(mtc[0]));
    check({tag, ".ovfa"}, int'(ovfa), int'(movf[0]));
    check({tag, ".qb"},   int'(qb),   mq[1]);
    check({tag, ".tcb"},  int'(tcb),  int'(mtc[1]));
    check({tag, ".ovfb"}, int'(ovfb), int'(movf[1]));
  endtask

  // Inputs are already driven; advance one edge and sample 1 time unit later
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic u, input logic s, input logic c,
                       input logic l, input logic [W-1:0] v, input logic o);
    en = e; up = u; sat_mode = s; clear = c; load = l; load_val = v; ovf_clr = o;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic e, input logic u, input logic s, input logic c,
                              input logic l, input int v, input logic o,
                              input int eq, input logic etc, input logic eovf);
    vec_t r;
    r.en = e; r.up = u; r.sat = s; r.clr = c; r.ld = l; r.lv = W'(v); r.oc = o;
    r.q = W'(eq); r.tc = etc; r.ovf = eovf;
    return r;
  endfunction

  initial begin
    drive(0, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #12;
    check("reset.q", int'(qa), 0);
    check("reset.tc", int'(tca), 0);
    check("reset.ovf", int'(ovfa), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Count up with wrap from reset
    for (int k = 1; k <= 9; k++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, k, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    // Load 3 and count down through the 0 -> 9 wrap
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 1));
    // Saturate at the top, load wins over en
    tbl.push_back(mk(1, 1, 1, 0, 1, 8, 0, 8, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 9, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 9, 1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 9, 1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 9, 1, 1));
    // Clear beats load and en; out-of-range load clamps
    tbl.push_back(mk(1, 1, 0, 1, 1, 5, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 15, 0, 9, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0));
    // ovf_clr on the same edge as a boundary: set wins
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].oc);
      cycle();
      check($sformatf("vec%0d.q", i),   int'(qa),   int'(tbl[i].q));
      check($sformatf("vec%0d.tc", i),  int'(tca),  int'(tbl[i].tc));
      check($sformatf("vec%0d.ovf", i), int'(ovfa), int'(tbl[i].ovf));
      check_model($sformatf("vec%0d.model", i));
    end

    // Prescale 3: 9 enabled edges, 2 idle, then phase carries on
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) cycle();
    check("presc.after9", int'(qb), 3);
    drive(0, 1, 0, 0, 0, 0, 0);
    cycle(); cycle();
    check("presc.hold", int'(qb), 3);
    drive(1, 1, 0, 0, 0, 0, 0);
    cycle();
    check("presc.plus1", int'(qb), 3);
    cycle();
    check("presc.plus2", int'(qb), 3);
    cycle();
    check("presc.plus3", int'(qb), 4);
    check_model("presc");

    // Async reset between edges at q=6 with ovf set
    drive(1, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 1, 6, 0);
    cycle();
    check("pre_rst.q", int'(qa), 6);
    check("pre_rst.ovf", int'(ovfa), 1);
    drive(1, 1, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst.q", int'(qa), 0);
    check("async_rst.tc", int'(tca), 0);
    check("async_rst.ovf", int'(ovfa), 0);
    check("async_rst.qb", int'(qb), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Prescaler phase lost across reset: next step needs 3 full enabled edges
    model_step();
    check("post_rst.qa", int'(qa), 1);
    check("post_rst.qb", int'(qb), 0);
    cycle();
    check("post_rst.qb2", int'(qb), 0);
    cycle();
    check("post_rst.qb3", int'(qb), 1);
    check_model("post_rst");

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 8), 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 14) == 0),
            W'($urandom), ($urandom_range(0, 9) == 0));
      cycle();
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
- Parametrised, fully synchronous up/down modulo counter. It is the successor to the 4-bit T-flip-flop ripple counter.
- All bits update on the same clk edge, so there is no ripple skew.
- Adds enable, direction, parallel load, synchronous clear, prescaler, wrap/saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used as the general event/timer counter in datapath and test blocks.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1 to 32.
- MOD_VAL, 16, count range is 0 to MOD_VAL-1; must satisfy 2 <= MOD_VAL <= 2^WIDTH.
- PRESCALE, 1, number of enabled cycles per count step; must be 1 or more, and 1 means step on every enabled cycle.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat_mode  input  1  boundary mode: 1 = saturate at the limit, 0 = wrap modulo MOD_VAL.
- clear  input  1  synchronous clear of q, prescaler and tc.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- ovf_clr  input  1  synchronous clear of the ovf flag.
- q  output  WIDTH  current count (registered).
- tc  output  1  registered one-cycle pulse on a boundary event.
- ovf  output  1  sticky flag, set by any boundary event.

Behaviour:
- Reset:
  - Asynchronous, active-high; takes effect immediately, independent of clk.
  - During reset: q=0, tc=0, ovf=0, prescaler count=0.
  - Counting resumes on the first rising edge after reset deasserts.
- Priority per edge: reset > clear > load > count step.
- clear: q=0, prescaler=0, tc=0. ovf is untouched.
- load:
  - q <= load_val; prescaler=0; tc=0.
  - If load_val >= MOD_VAL, q <= MOD_VAL-1 (clamped).
  - load wins over en in the same cycle.
- Prescaler:
  - Internal counter runs 0 to PRESCALE-1 and advances only when en=1.
  - A step occurs on the edge where en=1 and the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - With en=0 the prescaler holds its value.
  - With PRESCALE=1 the prescaler logic degenerates: every enabled edge is a step.
- Step, counting up:
  - If q < MOD_VAL-1: q+1.
  - If q = MOD_VAL-1: boundary event; q <= 0 when sat_mode=0, q holds MOD_VAL-1 when sat_mode=1.
- Step, counting down:
  - If q > 0: q-1.
  - If q = 0: boundary event; q <= MOD_VAL-1 when sat_mode=0, q holds 0 when sat_mode=1.
- Mode and direction timing: up and sat_mode are sampled on the step edge only. They may change on any cycle with no restart.
- tc:
  - Set to 1 on the edge of a boundary event, so it is high for the cycle after that edge; otherwise cleared to 0.
  - In saturate mode, each further step held at the limit is a new boundary event. tc therefore stays high while en and the direction keep pushing into the limit.
- ovf:
  - Set on any boundary event; cleared by ovf_clr.
  - If ovf_clr and a boundary event occur on the same edge, set wins and ovf=1.
- Latency: q reflects a step, load or clear one edge after it is sampled. There is no combinational path from any input to any output.
- Arithmetic: q never leaves the range 0 to MOD_VAL-1. With MOD_VAL = 2^WIDTH the wrap is the natural binary overflow.
- Reset mid-count: the prescaler phase is lost and the next step needs a full PRESCALE enabled cycles.

Test Plan:
- WIDTH=4, MOD_VAL=10, PRESCALE=1; up=1, en=1, sat_mode=0 for 12 cycles from reset -> q counts 0,1,...,9,0,1. tc is high for exactly the one cycle where q=0 after 9. ovf=1 from then on.
- Same configuration, load=1 with load_val=3, then up=0 for 5 cycles -> q counts 3,2,1,0,9,8. tc pulses after the 0->9 transition.
- sat_mode=1, up=1, starting from q=8, 4 enabled cycles -> q counts 9,9,9,9. tc is high for the last three cycles. ovf=1.
- PRESCALE=3, en held high for 9 cycles, then en=0 for 2 cycles, then en=1 for 1 cycle -> q increments every third enabled edge, giving q=3 after 9 cycles. q holds at 3 while en=0. The prescaler phase is preserved across the en=0 gap.
- On a single edge, drive clear=1, load=1 (load_val=5) and en=1 -> q=0. Separately, load_val=15 with MOD_VAL=10 -> q=9.
- Assert reset asynchronously between clock edges at q=6 with ovf=1 -> q, tc and ovf go to 0 before the next edge. Then, in a separate step, drive ovf_clr=1 on the same edge as a boundary event -> ovf=1.
